regbank_access_arbiter: RTL and testbench

- Shares the single register-bank access port between two requesters.
  - Requester 0: SPI register bridge.
  - Requester 1: on-chip housekeeping/telemetry sequencer.
- Serialises whole transactions with a 4-state FSM and fair round-robin arbitration.
- Completes reads on regbank valid, or terminates them on timeout with an error flag.
- Sits between the masters and the register bank in the core top.

---
 rtl/regbank_access_arbiter.sv | 171 +++++++++++++++++
 tb/tb_regbank_access_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_access_arbiter.sv
// Two-requester round-robin arbiter in front of the single register-bank port.
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_mX_req/we/addr/wdata : requester X transaction, held until o_mX_ack
//   o_mX_ack/rdata/err  : completion pulse, read data, read-timeout flag
//   o_rb_*              : register-bank strobes, address, write data
//   i_rb_rd_data/valid  : register-bank read return
//   o_busy, o_owner     : FSM not idle, current owner (0 when idle)
module regbank_access_arbiter #(
   parameter int K_DWIDTH  = 16,
   parameter int K_AWIDTH  = 8,
   parameter int K_TIMEOUT = 15
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_m0_req,
   input  logic                i_m0_we,
   input  logic [K_AWIDTH-1:0] i_m0_addr,
   input  logic [K_DWIDTH-1:0] i_m0_wdata,
   output logic                o_m0_ack,
   output logic [K_DWIDTH-1:0] o_m0_rdata,
   output logic                o_m0_err,
   input  logic                i_m1_req,
   input  logic                i_m1_we,
   input  logic [K_AWIDTH-1:0] i_m1_addr,
   input  logic [K_DWIDTH-1:0] i_m1_wdata,
   output logic                o_m1_ack,
   output logic [K_DWIDTH-1:0] o_m1_rdata,
   output logic                o_m1_err,
   output logic                o_rb_wr_en,
   output logic [K_AWIDTH-1:0] o_rb_addr,
   output logic [K_DWIDTH-1:0] o_rb_wr_data,
   output logic                o_rb_rd_en,
   input  logic [K_DWIDTH-1:0] i_rb_rd_data,
   input  logic                i_rb_rd_valid,
   output logic                o_busy,
   output logic                o_owner
);

   localparam int CW = $clog2(K_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t              state, state_nx;
   logic                owner, last_gnt, lat_we;
   logic [K_AWIDTH-1:0] lat_addr;
   logic [K_DWIDTH-1:0] lat_wdata;
   logic [CW-1:0]       tcnt;

   logic grant, gnt_idx;
   logic cap, tout, wr_done;
   logic tcnt_clr, tcnt_inc;
   logic res_ld;
   logic [K_DWIDTH-1:0] res_data;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      grant        = 1'b0;
      gnt_idx      = 1'b0;
      cap          = 1'b0;
      tout         = 1'b0;
      wr_done      = 1'b0;
      tcnt_clr     = 1'b0;
      tcnt_inc     = 1'b0;
      o_rb_wr_en   = 1'b0;
      o_rb_rd_en   = 1'b0;
      o_rb_addr    = '0;
      o_rb_wr_data = '0;
      unique case (state)
         S_IDLE: begin
            if (i_m0_req || i_m1_req) begin
               grant = 1'b1;
               // On a tie the requester not served last wins.
               gnt_idx  = (i_m0_req && i_m1_req) ? ~last_gnt : i_m1_req;
               state_nx = S_ISSUE;
            end
         end
         S_ISSUE: begin
            o_rb_addr = lat_addr;
            if (lat_we) begin
               o_rb_wr_en   = 1'b1;
               o_rb_wr_data = lat_wdata;
               wr_done      = 1'b1;
               state_nx     = S_DONE;
            end else begin
               o_rb_rd_en = 1'b1;
               if (i_rb_rd_valid) begin
                  cap      = 1'b1;
                  state_nx = S_DONE;
               end else begin
                  tcnt_clr = 1'b1;
                  state_nx = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // Valid has priority over a coincident timeout.
            if (i_rb_rd_valid) begin
               cap      = 1'b1;
               state_nx = S_DONE;
            end else if (tcnt == CW'(K_TIMEOUT - 1)) begin
               tout     = 1'b1;
               state_nx = S_DONE;
            end else begin
               tcnt_inc = 1'b1;
            end
         end
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         owner     <= 1'b0;
         last_gnt  <= 1'b1;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         tcnt      <= '0;
      end else begin
         if (grant) begin
            owner     <= gnt_idx;
            lat_we    <= gnt_idx ? i_m1_we    : i_m0_we;
            lat_addr  <= gnt_idx ? i_m1_addr  : i_m0_addr;
            lat_wdata <= gnt_idx ? i_m1_wdata : i_m0_wdata;
         end
         if (tcnt_clr)      tcnt <= '0;
         else if (tcnt_inc) tcnt <= tcnt + 1'b1;
         if (state == S_DONE) last_gnt <= owner;
      end
   end

   // Result registers load on entry to DONE so they are valid with ack
   // and then hold until the owner's next completion.
   assign res_ld   = cap | tout | wr_done;
   assign res_data = cap ? i_rb_rd_data : '0;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_m0_rdata <= '0;
         o_m0_err   <= 1'b0;
         o_m1_rdata <= '0;
         o_m1_err   <= 1'b0;
      end else if (res_ld) begin
         if (owner) begin
            o_m1_rdata <= res_data;
            o_m1_err   <= tout;
         end else begin
            o_m0_rdata <= res_data;
            o_m0_err   <= tout;
         end
      end
   end

   assign o_busy   = (state != S_IDLE);
   assign o_owner  = o_busy & owner;
   assign o_m0_ack = (state == S_DONE) & ~owner;
   assign o_m1_ack = (state == S_DONE) & owner;

endmodule

// File: tb/tb_regbank_access_arbiter.sv
// Directed bench for regbank_access_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_regbank_access_arbiter;

   logic        clk;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [7:0]  m0_addr, m1_addr;
   logic [15:0] m0_wdata, m1_wdata;
   logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
   logic [15:0] o_m0_rdata, o_m1_rdata;
   logic        o_rb_wr_en, o_rb_rd_en;
   logic [7:0]  o_rb_addr;
   logic [15:0] o_rb_wr_data;
   logic [15:0] rb_data;
   logic        rb_valid;
   logic        o_busy, o_owner;

   int n_vec;
   int n_bad;

   regbank_access_arbiter dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_m0_req     (m0_req),
      .i_m0_we      (m0_we),
      .i_m0_addr    (m0_addr),
      .i_m0_wdata   (m0_wdata),
      .o_m0_ack     (o_m0_ack),
      .o_m0_rdata   (o_m0_rdata),
      .o_m0_err     (o_m0_err),
      .i_m1_req     (m1_req),
      .i_m1_we      (m1_we),
      .i_m1_addr    (m1_addr),
      .i_m1_wdata   (m1_wdata),
      .o_m1_ack     (o_m1_ack),
      .o_m1_rdata   (o_m1_rdata),
      .o_m1_err     (o_m1_err),
      .o_rb_wr_en   (o_rb_wr_en),
      .o_rb_addr    (o_rb_addr),
      .o_rb_wr_data (o_rb_wr_data),
      .o_rb_rd_en   (o_rb_rd_en),
      .i_rb_rd_data (rb_data),
      .i_rb_rd_valid(rb_valid),
      .o_busy       (o_busy),
      .o_owner      (o_owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic ack_of(input int m);
      return (m == 1) ? o_m1_ack : o_m0_ack;
   endfunction

   function automatic logic [15:0] rdata_of(input int m);
      return (m == 1) ? o_m1_rdata : o_m0_rdata;
   endfunction

   function automatic logic err_of(input int m);
      return (m == 1) ? o_m1_err : o_m0_err;
   endfunction

   function automatic logic [31:0] flat_out();
      return {o_busy, o_owner, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err,
              o_rb_wr_en, o_rb_rd_en, o_rb_addr, o_rb_wr_data};
   endfunction

   task automatic set_req(input int m, input bit r, input bit we,
                          input logic [7:0] a, input logic [15:0] d);
      if (m == 0) begin
         m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
      end else begin
         m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
      end
   endtask

   task automatic drop_req(input int m);
      if (m == 0) m0_req = 1'b0;
      else        m1_req = 1'b0;
   endtask

   // Called at a falling edge with the DUT idle; that cycle is cycle 0.
   // v_at: cycle in which the bank returns valid (0 = never).
   // drop_at: cycle in which req is released early (0 = at ack).
   task automatic run_txn(input string tag, input int m, input bit we,
                          input logic [7:0] a, input logic [15:0] wd,
                          input int v_at, input logic [15:0] rd,
                          input int drop_at, input int exp_cyc,
                          input logic [15:0] exp_rd, input bit exp_err);
      bit got;
      got = 1'b0;
      set_req(m, 1'b1, we, a, wd);
      for (int k = 1; k <= 40 && !got; k++) begin
         @(negedge clk);
         if (k == 1) begin
            chk({tag, "/strobe"}, {o_rb_wr_en, o_rb_rd_en}, {we, ~we});
            chk({tag, "/addr"}, o_rb_addr, a);
            chk({tag, "/wdata"}, o_rb_wr_data, we ? wd : 16'h0);
         end
         if (ack_of(m)) begin
            got = 1'b1;
            chk({tag, "/cyc"}, 64'(k), 64'(exp_cyc));
            chk({tag, "/rdata"}, rdata_of(m), exp_rd);
            chk({tag, "/err"}, err_of(m), exp_err);
            chk({tag, "/other"}, ack_of(1 - m), 1'b0);
            chk({tag, "/owner"}, o_owner, m[0]);
            chk({tag, "/strb_off"}, {o_rb_wr_en, o_rb_rd_en}, 2'b00);
         end
         rb_valid = (k == v_at);
         rb_data  = (k == v_at) ? rd : 16'h0;
         if (got || k == drop_at) drop_req(m);
      end
      if (!got) chk({tag, "/noack"}, 1'b0, 1'b1);
      rb_valid = 1'b0;
      @(negedge clk);
      chk({tag, "/post"}, {o_busy, o_m0_ack, o_m1_ack}, 3'b000);
   endtask

   initial begin
      int n;
      bit got;
      n_vec = 0;
      n_bad = 0;
      rst = 1'b1;
      set_req(0, 1'b0, 1'b0, 8'h0, 16'h0);
      set_req(1, 1'b0, 1'b0, 8'h0, 16'h0);
      rb_valid = 1'b0;
      rb_data  = 16'h0;
      repeat (2) @(negedge clk);
      chk("rst/out", flat_out(), 32'h0);
      chk("rst/rdata", {o_m0_rdata, o_m1_rdata}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle/busy", {o_busy, o_owner}, 2'b00);

      run_txn("wr_m0", 0, 1'b1, 8'h12, 16'hBEEF, 0, 16'h0, 0,
              2, 16'h0, 1'b0);
      run_txn("rd0lat_m1", 1, 1'b0, 8'h00, 16'h0, 1, 16'hA001, 0,
              2, 16'hA001, 1'b0);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      set_req(0, 1'b1, 1'b1, 8'h01, 16'h1111);
      set_req(1, 1'b1, 1'b1, 8'h02, 16'h2222);
      n = 0;
      for (int k = 0; k < 30 && n < 4; k++) begin
         @(negedge clk);
         if (o_m0_ack || o_m1_ack) begin
            chk("alt/owner", o_owner, n[0]);
            chk("alt/ack", {o_m1_ack, o_m0_ack}, n[0] ? 2'b10 : 2'b01);
            n++;
         end
      end
      chk("alt/count", 64'(n), 64'd4);
      drop_req(0);
      drop_req(1);
      @(negedge clk);

      run_txn("rd_late", 0, 1'b0, 8'h20, 16'h0, 16, 16'h5A5A, 0,
              17, 16'h5A5A, 1'b0);
      run_txn("rd_tout", 0, 1'b0, 8'h21, 16'h0, 0, 16'h0, 0,
              17, 16'h0, 1'b1);
      run_txn("rd_drop", 0, 1'b0, 8'h22, 16'h0, 3, 16'h1234, 2,
              4, 16'h1234, 1'b0);

      rb_valid = 1'b1;
      rb_data  = 16'hDEAD;
      repeat (3) @(negedge clk);
      chk("stray", {o_busy, o_m0_ack, o_m1_ack}, 3'b000);
      chk("stray/rdata", o_m0_rdata, 16'h1234);
      rb_valid = 1'b0;
      rb_data  = 16'h0;

      set_req(0, 1'b1, 1'b0, 8'h30, 16'h0);
      repeat (5) @(negedge clk);
      chk("wait/busy", {o_busy, o_owner}, 2'b10);
      drop_req(0);
      set_req(1, 1'b1, 1'b1, 8'h44, 16'h7777);
      rst = 1'b1;
      #1;
      chk("mid_rst/out", flat_out(), 32'h0);
      chk("mid_rst/rdata", {o_m0_rdata, o_m1_rdata}, 32'h0);
      @(negedge clk);
      chk("mid_rst/hold", flat_out(), 32'h0);
      rst = 1'b0;
      got = 1'b0;
      for (int k = 1; k <= 10 && !got; k++) begin
         @(negedge clk);
         chk("post_rst/no_m0", o_m0_ack, 1'b0);
         if (o_m1_ack) begin
            got = 1'b1;
            chk("post_rst/cyc", 64'(k), 64'd2);
            chk("post_rst/res", {o_m1_rdata, o_m1_err}, 17'h0);
            drop_req(1);
         end
      end
      if (!got) chk("post_rst/noack", 1'b0, 1'b1);
      @(negedge clk);

      set_req(0, 1'b1, 1'b1, 8'h50, 16'h0005);
      set_req(1, 1'b1, 1'b1, 8'h51, 16'h0006);
      @(negedge clk);
      chk("tie/owner", o_owner, 1'b0);
      chk("tie/addr", o_rb_addr, 8'h50);
      drop_req(0);
      drop_req(1);
      repeat (2) @(negedge clk);
      chk("tie/idle", o_busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
